barrel_shifter_pipe: RTL and testbench

BARREL_SHIFTER_PIPE -- requirements
Module: barrel_shifter_pipe

---
 rtl/barrel_shifter_pipe.sv | 64 ++++++
 tb/tb_barrel_shifter_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined rotate/shift unit, one log2 stage per register, valid/ready flow control
module barrel_shifter_pipe #(
  parameter int WIDTH = 8,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    sel,
  input  logic [1:0]       mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] dout,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] data_q [SW];
  logic [SW-1:0]    sel_q  [SW];
  logic [1:0]       mode_q [SW];
  logic [SW-1:0]    valid_q;
  logic             stall;

  // Fixed-distance move used by every stage; s is a per-stage constant 2^k.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d,
                                            input logic [1:0] m,
                                            input int s);
    case (m)
      2'b00:   step = (d << s) | (d >> (WIDTH - s));
      2'b01:   step = (d >> s) | (d << (WIDTH - s));
      2'b10:   step = d << s;
      default: step = $signed(d) >>> s;
    endcase
  endfunction

  assign stall     = valid_q[SW-1] & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = valid_q[SW-1];
  assign dout      = data_q[SW-1];

  // The whole pipe freezes on a stall, so bubbles are never squeezed out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SW; k++) begin
        data_q[k] <= '0;
        sel_q[k]  <= '0;
        mode_q[k] <= '0;
      end
      valid_q <= '0;
    end else if (!stall) begin
      data_q[0]  <= sel[0] ? step(din, mode, 1) : din;
      sel_q[0]   <= sel;
      mode_q[0]  <= mode;
      valid_q[0] <= in_valid;
      for (int k = 1; k < SW; k++) begin
        data_q[k]  <= sel_q[k-1][k] ? step(data_q[k-1], mode_q[k-1], 1 << k) : data_q[k-1];
        sel_q[k]   <= sel_q[k-1];
        mode_q[k]  <= mode_q[k-1];
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - randomized and directed self-checking bench for barrel_shifter_pipe
module tb_barrel_shifter_pipe;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic [2:0]   sel;
  logic [1:0]   mode;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dout;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int passes = 0;

  typedef struct packed {
    logic [W-1:0] exp;
    logic [W-1:0] din;
    logic [2:0]   sel;
  } item_t;

  item_t q[$];

  barrel_shifter_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready),
    .dout(dout), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  // Bit-by-bit description of each operation: where every output bit comes from.
  function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input int s, input logic [1:0] m);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      case (m)
        2'b00:   r[i] = d[(i - s + W) % W];
        2'b01:   r[i] = d[(i + s) % W];
        2'b10:   r[i] = (i >= s) ? d[i - s] : 1'b0;
        default: r[i] = (i + s < W) ? d[i + s] : d[W-1];
      endcase
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] d, input logic [2:0] s,
                       input logic [1:0] m, input logic r);
    in_valid  = v;
    din       = d;
    sel       = s;
    mode      = m;
    out_ready = r;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 8'h00, 3'd0, 2'd0, 1'b0);
    rst = 1'b1;
    #23;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else passes++;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_modes;
    logic [W-1:0] d_tab [5] = '{8'b10110001, 8'b10110001, 8'b10110001, 8'b10110001, 8'b01110001};
    logic [2:0]   s_tab [5] = '{3'd3, 3'd1, 3'd2, 3'd3, 3'd3};
    logic [1:0]   m_tab [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [W-1:0] e_tab [5] = '{8'b10001101, 8'b11011000, 8'b11000100, 8'b11110110, 8'b00001110};
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, d_tab[i], s_tab[i], m_tab[i], 1'b1);
      next_cycle;
      drive(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
      #1;
      checks++; if (out_valid !== 1'b0) $display("FAIL modes_early1[%0d]: got out_valid %b expected 0", i, out_valid); else passes++;
      next_cycle;
      checks++; if (out_valid !== 1'b0) $display("FAIL modes_early2[%0d]: got out_valid %b expected 0", i, out_valid); else passes++;
      next_cycle;
      checks++; if (out_valid !== 1'b1) $display("FAIL modes_valid[%0d]: got out_valid %b expected 1", i, out_valid); else passes++;
      checks++; if (dout !== e_tab[i]) $display("FAIL modes_dout[%0d]: got %b expected %b", i, dout, e_tab[i]); else passes++;
      next_cycle;
      checks++; if (out_valid !== 1'b0) $display("FAIL modes_consumed[%0d]: got out_valid %b expected 0", i, out_valid); else passes++;
    end
  endtask

  task automatic test_exhaustive;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    item_t it;
    q.delete();
    while ((sent < 8192 || q.size() > 0) && cyc < 9000) begin
      if (sent < 8192) drive(1'b1, sent[7:0], sent[10:8], sent[12:11], 1'b1);
      else             drive(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
      #1;
      if (out_valid && out_ready) begin
        it = q.pop_front();
        got++;
        checks++; if (dout !== it.exp) $display("FAIL exh_dout: got %h expected %h (din %h sel %0d)", dout, it.exp, it.din, it.sel); else passes++;
        if (it.sel == 3'd0) begin
          checks++; if (dout !== it.din) $display("FAIL exh_sel0: got %h expected din %h", dout, it.din); else passes++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{exp: ref_model(din, int'(sel), mode), din: din, sel: sel});
        sent++;
      end
      next_cycle;
      cyc++;
    end
    checks++; if (got !== 8192) $display("FAIL exh_count: got %0d results expected 8192", got); else passes++;
    checks++; if (cyc !== 8195) $display("FAIL exh_throughput: got %0d cycles expected 8195", cyc); else passes++;
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got = 0;
    int stalls = 0;
    logic prev_stall = 1'b0;
    logic [W-1:0] prev_dout = '0;
    item_t it;
    q.delete();
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      drive(sent < 6, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), !(cyc >= 5 && cyc < 9));
      #1;
      if (out_valid && !out_ready) begin
        stalls++;
        checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b expected 0", in_ready); else passes++;
        if (prev_stall) begin
          checks++; if (dout !== prev_dout) $display("FAIL bp_dout_stable: got %h expected %h", dout, prev_dout); else passes++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_dout = dout;
      if (out_valid && out_ready) begin
        it = q.pop_front();
        got++;
        checks++; if (dout !== it.exp) $display("FAIL bp_dout: got %h expected %h", dout, it.exp); else passes++;
      end
      if (in_valid && in_ready) begin
        q.push_back('{exp: ref_model(din, int'(sel), mode), din: din, sel: sel});
        sent++;
      end
      next_cycle;
    end
    checks++; if (got !== 6) $display("FAIL bp_count: got %0d results expected 6", got); else passes++;
    checks++; if (stalls !== 4) $display("FAIL bp_stall_cycles: got %0d expected 4", stalls); else passes++;
    drive(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
  endtask

  task automatic test_random;
    int got = 0;
    int sent = 0;
    int cyc = 0;
    item_t it;
    q.delete();
    while ((cyc < 400 || q.size() > 0) && cyc < 500) begin
      drive((cyc < 400) && ($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)),
            3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            (cyc >= 400) || ($urandom_range(0, 1) == 1));
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; $display("FAIL rnd_spurious: got unexpected result %h expected none", dout);
        end else begin
          it = q.pop_front();
          got++;
          checks++; if (dout !== it.exp) $display("FAIL rnd_dout: got %h expected %h", dout, it.exp); else passes++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back('{exp: ref_model(din, int'(sel), mode), din: din, sel: sel});
        sent++;
      end
      next_cycle;
      cyc++;
    end
    checks++; if (got !== sent) $display("FAIL rnd_count: got %0d results expected %0d", got, sent); else passes++;
    drive(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
  endtask

  task automatic test_reset_midflight;
    logic [W-1:0] d;
    logic [2:0]   s;
    logic [1:0]   m;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'b1);
      next_cycle;
    end
    drive(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
    #1;
    checks++; if (out_valid !== 1'b1) $display("FAIL rstm_inflight: got out_valid %b expected 1", out_valid); else passes++;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstm_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (dout !== 8'h00) $display("FAIL rstm_dout: got %h expected 00", dout); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstm_in_ready: got %b expected 1", in_ready); else passes++;
    next_cycle;
    next_cycle;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      next_cycle;
      checks++; if (out_valid !== 1'b0) $display("FAIL rstm_stale[%0d]: got out_valid %b expected 0", i, out_valid); else passes++;
    end
    d = 8'($urandom_range(0, 255));
    s = 3'($urandom_range(1, 7));
    m = 2'($urandom_range(0, 3));
    drive(1'b1, d, s, m, 1'b1);
    next_cycle;
    drive(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstm_lat1: got out_valid %b expected 0", out_valid); else passes++;
    next_cycle;
    checks++; if (out_valid !== 1'b0) $display("FAIL rstm_lat2: got out_valid %b expected 0", out_valid); else passes++;
    next_cycle;
    checks++; if (out_valid !== 1'b1) $display("FAIL rstm_lat3: got out_valid %b expected 1", out_valid); else passes++;
    checks++; if (dout !== ref_model(d, int'(s), m)) $display("FAIL rstm_dout: got %h expected %h", dout, ref_model(d, int'(s), m)); else passes++;
    next_cycle;
  endtask

  task automatic test_bubbles;
    logic         pat [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [W-1:0] d_hist [8];
    logic [2:0]   s_hist [8];
    logic [1:0]   m_hist [8];
    logic         exp_ov;
    for (int j = 0; j < 8; j++) begin
      d_hist[j] = 8'($urandom_range(0, 255));
      s_hist[j] = 3'($urandom_range(0, 7));
      m_hist[j] = 2'($urandom_range(0, 3));
      drive(pat[j], d_hist[j], s_hist[j], m_hist[j], 1'b1);
      #1;
      if (j >= 1) begin
        exp_ov = (j >= 3) ? pat[j-3] : 1'b0;
        checks++; if (out_valid !== exp_ov) $display("FAIL bub_valid[%0d]: got %b expected %b", j, out_valid, exp_ov); else passes++;
        if (exp_ov) begin
          checks++;
          if (dout !== ref_model(d_hist[j-3], int'(s_hist[j-3]), m_hist[j-3]))
            $display("FAIL bub_dout[%0d]: got %h expected %h", j, dout, ref_model(d_hist[j-3], int'(s_hist[j-3]), m_hist[j-3]));
          else passes++;
        end
      end
      next_cycle;
    end
    drive(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_modes;
    test_bubbles;
    test_backpressure;
    test_reset_midflight;
    test_random;
    test_exhaustive;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
